sc_spi_tgt: RTL and testbench
=============================

Name: sc_spi_tgt

Overview:
SPI target-side protocol engine. It is the far end of the link driven by the SPI clock generator, and it decodes the SCK/CSB/MOSI stream produced by a controller. All SPI inputs are oversampled in the single system clock domain. The block deserialises MOSI into words, serialises a buffered TX word onto MISO, and exposes a simple valid/ready word interface to the register block.

Parameters:
DATA_WIDTH, 8, bits per SPI word, MSB first; legal range 4..32
SYNC_STAGES, 2, flip-flop synchroniser depth on SCK_IN/CSB_IN/MOSI_IN; minimum 2

Ports:
SRCCLK  input  1  system clock; all logic on posedge
SYSRST  input  1  synchronous, active-high reset
ENABLE  input  1  target enable; when low, new frames are ignored
SPI_MODE  input  2  bit1 = CPOL, bit0 = CPHA; sampled at frame start only
SCK_IN  input  1  SPI clock from controller, asynchronous
CSB_IN  input  1  chip select, active low, asynchronous
MOSI_IN  input  1  serial data in, asynchronous
MISO_OUT  output  1  serial data out
MISO_OE  output  1  MISO output enable, high while selected
TX_DATA  input  DATA_WIDTH  next word to transmit
TX_VALID  input  1  TX_DATA is valid
TX_READY  output  1  TX holding register is empty
RX_DATA  output  DATA_WIDTH  last complete received word
RX_VALID  output  1  one-cycle pulse: RX_DATA updated
TX_UNDERRUN  output  1  one-cycle pulse: word load found the holding register empty
FRAME_ABORT  output  1  one-cycle pulse: CSB rose mid-word
BUSY  output  1  high in ACTIVE state

Behaviour:
- Reset (SYSRST=1 at a posedge): state=IDLE. MISO_OUT=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, TX_UNDERRUN=0, FRAME_ABORT=0, BUSY=0. Synchronisers, shift registers, holding register, bit counter and skip flag are all cleared. Reset overrides any frame in progress.
- Synchronisers: SCK/CSB/MOSI each pass through SYNC_STAGES flops. Edges are detected from the last synchronised stage against a one-cycle-delayed copy.
- Timing requirement: each SCK phase lasts at least 2 SRCCLK periods. Faster SCK is out of spec.
- Edge decode (mode latched at frame start):
  - Leading edge = rising when CPOL=0, falling when CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- TX holding register: when TX_VALID & TX_READY at a posedge, TX_DATA is captured and TX_READY drops the next cycle. Moving the word into the shift register empties the holding register, so TX_READY=1 the next cycle. Load and new capture in the same cycle are allowed: load takes the old contents and the holding register takes the new word.
- Word load: the shift register is loaded from the holding register. If the holding register is empty, it is loaded with all-ones and TX_UNDERRUN pulses. MISO_OUT always equals the shift register MSB.
- States:
  - IDLE -> ACTIVE on a synchronised CSB falling edge while ENABLE=1. In that cycle: latch SPI_MODE, clear bit_cnt, load a word, set MISO_OE=1. Set the skip flag only if CPHA=1.
  - ACTIVE, sample edge: rx_shift <= {rx_shift[W-2:0], mosi_s} and bit_cnt increments. When bit_cnt==W-1, in the same cycle:
    - RX_DATA <= completed word; RX_VALID pulses on the next cycle (concurrent with the RX_DATA update).
    - bit_cnt wraps to 0.
    - A new word is loaded and the skip flag is set, regardless of mode.
  - ACTIVE, shift edge: if the skip flag is set, clear it and do not shift. Otherwise shift left by one, filling with 0.
  - ACTIVE -> IDLE on a synchronised CSB rising edge. MISO_OE=0 and MISO_OUT=0 the next cycle.
    - If bit_cnt != 0, the partial word is discarded, FRAME_ABORT pulses and RX_VALID is not asserted.
    - The holding register keeps its contents.
  - ENABLE falling while ACTIVE: the current frame completes normally. ENABLE is checked only at the IDLE->ACTIVE transition.
- Simultaneous events: a CSB rising edge in the same cycle as a sample edge is handled as the CSB rising edge only (the sample is ignored).
- Latency: RX_VALID is high exactly SYNC_STAGES+2 SRCCLK cycles after the raw final sample edge reaches SCK_IN.

Test Plan:
- Mode 0, W=8: preload TX=0xA5, controller sends 0x3C -> MISO bits observed 1,0,1,0,0,1,0,1; RX_VALID single pulse with RX_DATA=0x3C; TX_READY back to 1 after frame start.
- Mode 3: two back-to-back words, TX 0x81 then 0x7E loaded via handshake between them; controller sends 0xF0, 0x0F -> two RX_VALID pulses (0xF0, 0x0F); MISO 0x81 then 0x7E; no TX_UNDERRUN.
- Modes 1 and 2, empty holding register -> MISO all-ones word; TX_UNDERRUN pulses once per load; RX still correct.
- CSB deasserted after 5 bits -> FRAME_ABORT pulse, no RX_VALID, MISO_OE=0; next full frame receives correctly from bit_cnt=0.
- ENABLE=0 at CSB fall -> BUSY stays 0, MISO_OE stays 0, no RX_VALID for the whole frame.
- SYSRST asserted mid-word -> all outputs at reset values next cycle; TX_READY=1; subsequent frame operates normally.

Source files
------------

// File: rtl/sc_spi_tgt.sv
// SPI target engine: oversamples SCK/CSB/MOSI in the SRCCLK domain, deserialises MOSI,
// serialises a buffered TX word onto MISO and exposes a valid/ready word interface.
module sc_spi_tgt #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  SRCCLK,
    input  logic                  SYSRST,
    input  logic                  ENABLE,
    input  logic [1:0]            SPI_MODE,
    input  logic                  SCK_IN,
    input  logic                  CSB_IN,
    input  logic                  MOSI_IN,
    output logic                  MISO_OUT,
    output logic                  MISO_OE,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  TX_UNDERRUN,
    output logic                  FRAME_ABORT,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   csb_d;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   csb_rise;
    logic                   csb_fall;
    logic                   mosi_q;

    logic [1:0]            mode_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  skip;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;

    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic start_frame;
    logic end_frame;
    logic do_sample;
    logic do_shift;
    logic word_done;
    logic load_word;
    logic tx_capture;

    // Edge strobes are registered; MOSI is delayed alongside so data stays aligned with its strobe.
    always_ff @(posedge SRCCLK) begin
        if (SYSRST) begin
            sck_sync  <= '0;
            csb_sync  <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            csb_d     <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            csb_rise  <= 1'b0;
            csb_fall  <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_IN};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], CSB_IN};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_IN};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            csb_d     <= csb_sync[SYNC_STAGES-1];
            sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_d;
            sck_fall  <= ~sck_sync[SYNC_STAGES-1] & sck_d;
            csb_rise  <= csb_sync[SYNC_STAGES-1] & ~csb_d;
            csb_fall  <= ~csb_sync[SYNC_STAGES-1] & csb_d;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign lead_edge   = mode_q[1] ? sck_fall : sck_rise;
    assign trail_edge  = mode_q[1] ? sck_rise : sck_fall;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

    always_ff @(posedge SRCCLK) begin
        if (SYSRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (csb_fall && ENABLE) state_next = ACTIVE;
            ACTIVE:  if (csb_rise)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A CSB rising edge masks any SCK edge decoded in the same cycle.
    always_comb begin
        start_frame = 1'b0;
        end_frame   = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        BUSY        = (state == ACTIVE);
        case (state)
            IDLE: begin
                start_frame = csb_fall & ENABLE;
            end
            ACTIVE: begin
                if (csb_rise) begin
                    end_frame = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
            default: begin
                start_frame = 1'b0;
            end
        endcase
    end

    assign word_done  = do_sample & (bit_cnt == LAST_BIT);
    assign load_word  = start_frame | word_done;
    assign tx_capture = TX_VALID & ~hold_full;

    always_ff @(posedge SRCCLK) begin
        if (SYSRST) begin
            hold_data   <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            skip        <= 1'b0;
            mode_q      <= 2'b00;
            MISO_OE     <= 1'b0;
            RX_DATA     <= '0;
            RX_VALID    <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            FRAME_ABORT <= 1'b0;
        end else begin
            RX_VALID    <= word_done;
            TX_UNDERRUN <= load_word & ~hold_full;
            FRAME_ABORT <= end_frame & (bit_cnt != '0);

            // A load drains the old word while a same-cycle capture refills the register.
            hold_full <= (hold_full & ~load_word) | tx_capture;
            if (tx_capture) begin
                hold_data <= TX_DATA;
            end

            if (load_word) begin
                tx_shift <= hold_full ? hold_data : '1;
            end else if (end_frame) begin
                tx_shift <= '0;
            end else if (do_shift && !skip) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (start_frame) begin
                mode_q   <= SPI_MODE;
                bit_cnt  <= '0;
                skip     <= SPI_MODE[0];
                rx_shift <= '0;
                MISO_OE  <= 1'b1;
            end else if (end_frame) begin
                bit_cnt <= '0;
                MISO_OE <= 1'b0;
            end else if (do_sample) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_q};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    RX_DATA <= {rx_shift[DATA_WIDTH-2:0], mosi_q};
                    skip    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (do_shift && skip) begin
                skip <= 1'b0;
            end
        end
    end

    assign MISO_OUT = tx_shift[DATA_WIDTH-1];
    assign TX_READY = ~hold_full;

endmodule

// File: tb/tb_sc_spi_tgt.sv
// Directed bench for sc_spi_tgt: a behavioural SPI controller drives frames in all four modes
// while a scoreboard queue holds the words the target should report on RX_DATA.
module tb_sc_spi_tgt;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic         SRCCLK;
    logic         SYSRST;
    logic         ENABLE;
    logic [1:0]   SPI_MODE;
    logic         SCK_IN;
    logic         CSB_IN;
    logic         MOSI_IN;
    logic         MISO_OUT;
    logic         MISO_OE;
    logic [W-1:0] TX_DATA;
    logic         TX_VALID;
    logic         TX_READY;
    logic [W-1:0] RX_DATA;
    logic         RX_VALID;
    logic         TX_UNDERRUN;
    logic         FRAME_ABORT;
    logic         BUSY;

    sc_spi_tgt #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .SRCCLK      (SRCCLK),
        .SYSRST      (SYSRST),
        .ENABLE      (ENABLE),
        .SPI_MODE    (SPI_MODE),
        .SCK_IN      (SCK_IN),
        .CSB_IN      (CSB_IN),
        .MOSI_IN     (MOSI_IN),
        .MISO_OUT    (MISO_OUT),
        .MISO_OE     (MISO_OE),
        .TX_DATA     (TX_DATA),
        .TX_VALID    (TX_VALID),
        .TX_READY    (TX_READY),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .TX_UNDERRUN (TX_UNDERRUN),
        .FRAME_ABORT (FRAME_ABORT),
        .BUSY        (BUSY)
    );

    initial SRCCLK = 1'b0;
    always #5 SRCCLK = ~SRCCLK;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int cycleCount = 0;
    int rxCount = 0;
    int underrunCount = 0;
    int abortCount = 0;
    int lastRxCycle = 0;
    int lastSampleCycle = 0;
    logic [W-1:0] rxQueue[$];
    logic cpol = 1'b0;
    logic cpha = 1'b0;

    always @(posedge SRCCLK) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every RX_VALID pulse must match the oldest word the controller sent.
    always @(negedge SRCCLK) begin
        if (!SYSRST) begin
            if (RX_VALID) begin
                rxCount++;
                lastRxCycle = cycleCount;
                checkOutput("rx_expected_pending", 32'(rxQueue.size() > 0), 32'd1);
                if (rxQueue.size() > 0) checkOutput("rx_data", 32'(RX_DATA), 32'(rxQueue.pop_front()));
            end
            if (TX_UNDERRUN) underrunCount++;
            if (FRAME_ABORT) abortCount++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SRCCLK);
        #1;
    endtask

    task automatic setMode(input logic [1:0] m);
        cpol     = m[1];
        cpha     = m[0];
        SPI_MODE = m;
        SCK_IN   = m[1];
        tick(HALF);
    endtask

    task automatic loadTx(input logic [W-1:0] word);
        int n = 0;
        while (!TX_READY && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput("tx_ready_wait", 32'(TX_READY), 32'd1);
        TX_DATA  = word;
        TX_VALID = 1'b1;
        tick(1);
        TX_VALID = 1'b0;
    endtask

    task automatic startFrame();
        CSB_IN = 1'b0;
        tick(HALF);
    endtask

    task automatic endFrame();
        tick(HALF);
        CSB_IN = 1'b1;
        tick(HALF);
    endtask

    // Controller model: drives nBits MSB-first and captures MISO at each sample edge.
    task automatic applyStimulus(input logic [W-1:0] mosiWord, input int nBits, input bit expectRx,
                                 output logic [W-1:0] misoWord);
        misoWord = '0;
        if (expectRx) rxQueue.push_back(mosiWord);
        for (int i = W - 1; i >= W - nBits; i--) begin
            if (!cpha) begin
                MOSI_IN = mosiWord[i];
                tick(HALF);
                misoWord[i] = MISO_OUT;
                SCK_IN = ~cpol;
                lastSampleCycle = cycleCount;
                tick(HALF);
                SCK_IN = cpol;
            end else begin
                SCK_IN  = ~cpol;
                MOSI_IN = mosiWord[i];
                tick(HALF);
                misoWord[i] = MISO_OUT;
                SCK_IN = cpol;
                lastSampleCycle = cycleCount;
                tick(HALF);
            end
        end
    endtask

    task automatic checkResetOutputs(input string p);
        checkOutput({p, "_miso_out"}, 32'(MISO_OUT), 32'd0);
        checkOutput({p, "_miso_oe"}, 32'(MISO_OE), 32'd0);
        checkOutput({p, "_tx_ready"}, 32'(TX_READY), 32'd1);
        checkOutput({p, "_rx_data"}, 32'(RX_DATA), 32'd0);
        checkOutput({p, "_rx_valid"}, 32'(RX_VALID), 32'd0);
        checkOutput({p, "_tx_underrun"}, 32'(TX_UNDERRUN), 32'd0);
        checkOutput({p, "_frame_abort"}, 32'(FRAME_ABORT), 32'd0);
        checkOutput({p, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] m1;
        logic [W-1:0] m2;
        int r0;
        int u0;
        int a0;

        SYSRST   = 1'b1;
        ENABLE   = 1'b1;
        SPI_MODE = 2'b00;
        SCK_IN   = 1'b0;
        CSB_IN   = 1'b1;
        MOSI_IN  = 1'b0;
        TX_DATA  = '0;
        TX_VALID = 1'b0;
        tick(3);
        checkResetOutputs("reset");
        SYSRST = 1'b0;
        tick(4);

        $display("[TB] mode 0 single word");
        setMode(2'd0);
        loadTx(8'hA5);
        checkOutput("m0_tx_ready_after_capture", 32'(TX_READY), 32'd0);
        r0 = rxCount; u0 = underrunCount; a0 = abortCount;
        startFrame();
        checkOutput("m0_busy", 32'(BUSY), 32'd1);
        checkOutput("m0_miso_oe", 32'(MISO_OE), 32'd1);
        checkOutput("m0_tx_ready_after_start", 32'(TX_READY), 32'd1);
        applyStimulus(8'h3C, W, 1'b1, m1);
        checkOutput("m0_miso_word", 32'(m1), 32'hA5);
        endFrame();
        checkOutput("m0_rx_pulses", 32'(rxCount - r0), 32'd1);
        checkOutput("m0_rx_latency", 32'(lastRxCycle - lastSampleCycle), 32'(SYNC + 2));
        checkOutput("m0_underrun_end_reload", 32'(underrunCount - u0), 32'd1);
        checkOutput("m0_no_abort", 32'(abortCount - a0), 32'd0);
        checkOutput("m0_idle_miso_oe", 32'(MISO_OE), 32'd0);
        checkOutput("m0_idle_miso_out", 32'(MISO_OUT), 32'd0);
        checkOutput("m0_idle_busy", 32'(BUSY), 32'd0);

        $display("[TB] mode 3 back-to-back words");
        setMode(2'd3);
        loadTx(8'h81);
        r0 = rxCount; u0 = underrunCount;
        startFrame();
        loadTx(8'h7E);
        applyStimulus(8'hF0, W, 1'b1, m1);
        loadTx(8'h55);
        applyStimulus(8'h0F, W, 1'b1, m2);
        endFrame();
        checkOutput("m3_miso_word0", 32'(m1), 32'h81);
        checkOutput("m3_miso_word1", 32'(m2), 32'h7E);
        checkOutput("m3_rx_pulses", 32'(rxCount - r0), 32'd2);
        checkOutput("m3_no_underrun", 32'(underrunCount - u0), 32'd0);

        $display("[TB] modes 1 and 2 with empty holding register");
        for (int m = 1; m <= 2; m++) begin
            setMode(2'(m));
            r0 = rxCount; u0 = underrunCount;
            startFrame();
            applyStimulus((m == 1) ? 8'hC9 : 8'h36, W, 1'b1, m1);
            endFrame();
            checkOutput($sformatf("m%0d_miso_all_ones", m), 32'(m1), 32'hFF);
            checkOutput($sformatf("m%0d_underruns", m), 32'(underrunCount - u0), 32'd2);
            checkOutput($sformatf("m%0d_rx_pulses", m), 32'(rxCount - r0), 32'd1);
        end

        $display("[TB] abort after 5 bits");
        setMode(2'd0);
        r0 = rxCount; a0 = abortCount;
        startFrame();
        applyStimulus(8'hB7, 5, 1'b0, m1);
        endFrame();
        checkOutput("abort_pulse", 32'(abortCount - a0), 32'd1);
        checkOutput("abort_no_rx", 32'(rxCount - r0), 32'd0);
        checkOutput("abort_miso_oe", 32'(MISO_OE), 32'd0);
        loadTx(8'h69);
        r0 = rxCount; a0 = abortCount;
        startFrame();
        applyStimulus(8'h96, W, 1'b1, m1);
        endFrame();
        checkOutput("after_abort_miso_word", 32'(m1), 32'h69);
        checkOutput("after_abort_rx_pulses", 32'(rxCount - r0), 32'd1);
        checkOutput("after_abort_no_abort", 32'(abortCount - a0), 32'd0);

        $display("[TB] frame ignored while disabled");
        ENABLE = 1'b0;
        r0 = rxCount;
        startFrame();
        checkOutput("dis_busy", 32'(BUSY), 32'd0);
        checkOutput("dis_miso_oe", 32'(MISO_OE), 32'd0);
        applyStimulus(8'hE1, W, 1'b0, m1);
        checkOutput("dis_miso_oe_late", 32'(MISO_OE), 32'd0);
        endFrame();
        checkOutput("dis_no_rx", 32'(rxCount - r0), 32'd0);
        checkOutput("dis_busy_end", 32'(BUSY), 32'd0);
        ENABLE = 1'b1;

        $display("[TB] reset mid-word");
        setMode(2'd0);
        loadTx(8'hC3);
        startFrame();
        loadTx(8'h11);
        applyStimulus(8'hAA, 3, 1'b0, m1);
        SYSRST = 1'b1;
        tick(1);
        checkResetOutputs("rst_mid");
        CSB_IN = 1'b1;
        SCK_IN = 1'b0;
        tick(2);
        SYSRST = 1'b0;
        tick(HALF);
        loadTx(8'h24);
        r0 = rxCount;
        startFrame();
        applyStimulus(8'h42, W, 1'b1, m1);
        endFrame();
        checkOutput("post_rst_miso_word", 32'(m1), 32'h24);
        checkOutput("post_rst_rx_pulses", 32'(rxCount - r0), 32'd1);

        checkOutput("scoreboard_empty", 32'(rxQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
